ram_dp: RTL and testbench

RAM_DP -- requirements
Module: ram_dp

---
 rtl/ram_dp_pkg.sv | 16 +
 rtl/ram_dp_sweep.sv | 53 +++++
 rtl/ram_dp.sv | 106 ++++++++++
 tb/tb_ram_dp.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// Shared types and helpers for the ram_dp dual-port RAM with a zero-sweep clear.
package ram_dp_pkg;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    localparam int unsigned PARITY_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_dp_sweep.sv
// Sweep controller for ram_dp: IDLE/SWEEP FSM, ascending sweep address and busy flag.
module ram_dp_sweep
    import ram_dp_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] addr
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SWEEP;
            addr  <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = SWEEP;
                    addr_next  = '0;
                end
            end
            SWEEP: begin
                addr_next = addr + ADDR_W'(1);
                if (addr == '1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = SWEEP;
                addr_next  = '0;
            end
        endcase
    end

    assign busy = (state == SWEEP);

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM (port A read/write, port B read-only) with 1-cycle read latency and zero-sweep clear.
// Optional per-word even parity with fault injection when RAM_DP_PARITY_EN is defined.
module ram_dp
    import ram_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    output logic              busy_o,
    input  logic              a_load_i,
    input  logic              a_rd_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
`ifdef RAM_DP_PARITY_EN
    input  logic              a_perr_inj_i,
    output logic              a_perr_o,
    output logic              b_perr_o,
`endif
    output logic [DATA_W-1:0] a_data_o,
    output logic              a_valid_o,
    input  logic              b_rd_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [DATA_W-1:0] b_data_o,
    output logic              b_valid_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_DP_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] sweep_addr;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  a_word;
    logic [MEM_W-1:0]  b_word;
    logic              a_take;
    logic              b_take;
    logic              a_write;

    ram_dp_sweep #(
        .ADDR_W(ADDR_W)
    ) u_sweep (
        .clk  (clk_i),
        .reset(reset_i),
        .clear(clear_i),
        .busy (busy_o),
        .addr (sweep_addr)
    );

    assign a_take  = a_rd_i && !busy_o;
    assign b_take  = b_rd_i && !busy_o;
    assign a_write = a_load_i && !busy_o;
    assign a_word  = mem[a_addr_i];
    assign b_word  = mem[b_addr_i];

`ifdef RAM_DP_PARITY_EN
    assign wr_word = {even_parity(PARITY_MAX_W'(a_data_i)) ^ a_perr_inj_i, a_data_i};
`else
    assign wr_word = a_data_i;
`endif

    // All-zero word carries parity 0, so the sweep needs no parity computation.
    always_ff @(posedge clk_i) begin
        if (busy_o) begin
            mem[sweep_addr] <= '0;
        end else if (a_write) begin
            mem[a_addr_i] <= wr_word;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_data_o  <= '0;
            b_data_o  <= '0;
            a_valid_o <= 1'b0;
            b_valid_o <= 1'b0;
`ifdef RAM_DP_PARITY_EN
            a_perr_o  <= 1'b0;
            b_perr_o  <= 1'b0;
`endif
        end else begin
            a_valid_o <= a_take;
            b_valid_o <= b_take;
            if (a_take) begin
                a_data_o <= a_word[DATA_W-1:0];
            end
            if (b_take) begin
                b_data_o <= b_word[DATA_W-1:0];
            end
`ifdef RAM_DP_PARITY_EN
            a_perr_o <= a_take &&
                        (a_word[DATA_W] != even_parity(PARITY_MAX_W'(a_word[DATA_W-1:0])));
            b_perr_o <= b_take &&
                        (b_word[DATA_W] != even_parity(PARITY_MAX_W'(b_word[DATA_W-1:0])));
`endif
        end
    end

endmodule

// File: tb/tb_ram_dp.sv
// Scoreboard bench for ram_dp (ADDR_W=4, DATA_W=16) against an array-level reference model.
module tb_ram_dp;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_i, clear_i, busy_o;
    logic          a_load_i, a_rd_i, b_rd_i;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [DW-1:0] a_data_i, a_data_o, b_data_o;
    logic          a_valid_o, b_valid_o;
    logic          perr_inj;
    logic          a_perr, b_perr;

    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic          model_bad [DEPTH];
    logic          model_busy = 1'b1;
    int            remaining = DEPTH;
    logic          drv_started = 1'b0;
    exp_t          qa[$];
    exp_t          qb[$];

    logic          rst_q = 1'b0;
    logic          mon_started = 1'b0;
    logic [DW-1:0] last_a, last_b;

    always #5 clk = ~clk;

    ram_dp #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .a_load_i    (a_load_i),
        .a_rd_i      (a_rd_i),
        .a_addr_i    (a_addr_i),
        .a_data_i    (a_data_i),
`ifdef RAM_DP_PARITY_EN
        .a_perr_inj_i(perr_inj),
        .a_perr_o    (a_perr),
        .b_perr_o    (b_perr),
`endif
        .a_data_o    (a_data_o),
        .a_valid_o   (a_valid_o),
        .b_rd_i      (b_rd_i),
        .b_addr_i    (b_addr_i),
        .b_data_o    (b_data_o),
        .b_valid_o   (b_valid_o)
    );

`ifndef RAM_DP_PARITY_EN
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        clear_i  = 1'b0;
        a_load_i = 1'b0;
        a_rd_i   = 1'b0;
        b_rd_i   = 1'b0;
        perr_inj = 1'b0;
    endtask

    // Reference: a sweep is an opaque DEPTH-cycle blackout that leaves every word zero.
    task automatic tick();
        if (reset_i) begin
            model_busy  = 1'b1;
            remaining   = DEPTH;
            drv_started = 1'b1;
        end else if (model_busy) begin
            remaining--;
            if (remaining == 0) begin
                model_busy = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    model_mem[i] = '0;
                    model_bad[i] = 1'b0;
                end
            end
        end else begin
            if (a_rd_i) qa.push_back('{model_mem[a_addr_i], model_bad[a_addr_i]});
            if (b_rd_i) qb.push_back('{model_mem[b_addr_i], model_bad[b_addr_i]});
            if (a_load_i) begin
                model_mem[a_addr_i] = a_data_i;
                model_bad[a_addr_i] = perr_inj;
            end
            if (clear_i) begin
                model_busy = 1'b1;
                remaining  = DEPTH;
            end
        end
        @(posedge clk);
        #1;
        if (drv_started) check("busy", busy_o, model_busy);
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic inj);
        set_idle();
        a_load_i = 1'b1;
        a_addr_i = addr;
        a_data_i = data;
        perr_inj = inj;
        tick();
        set_idle();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            set_idle();
            a_rd_i   = 1'b1;
            a_addr_i = AW'(i);
            b_rd_i   = 1'b1;
            b_addr_i = AW'(DEPTH - 1 - i);
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic random_cycle(input bit allow_clear);
        a_load_i = 1'($urandom_range(0, 1));
        a_rd_i   = 1'($urandom_range(0, 1));
        b_rd_i   = 1'($urandom_range(0, 1));
        a_addr_i = AW'($urandom_range(0, DEPTH - 1));
        b_addr_i = AW'($urandom_range(0, DEPTH - 1));
        a_data_i = DW'($urandom);
        clear_i  = allow_clear && ($urandom_range(0, 39) == 0);
`ifdef RAM_DP_PARITY_EN
        perr_inj = ($urandom_range(0, 3) == 0);
`endif
        tick();
    endtask

    always @(posedge clk) rst_q <= reset_i;

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            mon_started = 1'b1;
            check("rst_a_data", a_data_o, 0);
            check("rst_b_data", b_data_o, 0);
            check("rst_a_valid", a_valid_o, 0);
            check("rst_b_valid", b_valid_o, 0);
            check("rst_a_perr", a_perr, 0);
            check("rst_b_perr", b_perr, 0);
            last_a = '0;
            last_b = '0;
        end else if (mon_started) begin
            if (a_valid_o) begin
                if (qa.size() == 0) begin
                    check("a_valid_unexpected", a_valid_o, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_data", a_data_o, e.data);
                    check("a_perr", a_perr, e.perr);
                end
                last_a = a_data_o;
            end else begin
                check("a_hold", a_data_o, last_a);
                check("a_perr_idle", a_perr, 0);
            end
            if (b_valid_o) begin
                if (qb.size() == 0) begin
                    check("b_valid_unexpected", b_valid_o, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_data", b_data_o, e.data);
                    check("b_perr", b_perr, e.perr);
                end
                last_b = b_data_o;
            end else begin
                check("b_hold", b_data_o, last_b);
                check("b_perr_idle", b_perr, 0);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            model_bad[i] = 1'b0;
        end
        set_idle();
        a_addr_i = '0;
        b_addr_i = '0;
        a_data_i = '0;
        reset_i  = 1'b1;
        tick();
        reset_i = 1'b0;
        repeat (DEPTH) tick();
        read_all();

        write_a(4'd3, 16'hBEEF, 1'b0);
        a_rd_i   = 1'b1;
        a_addr_i = 4'd3;
        tick();
        set_idle();
        repeat (2) tick();

        write_a(4'd5, 16'h1111, 1'b0);
        a_load_i = 1'b1;
        a_addr_i = 4'd5;
        a_data_i = 16'h2222;
        b_rd_i   = 1'b1;
        b_addr_i = 4'd5;
        tick();
        set_idle();
        b_rd_i   = 1'b1;
        b_addr_i = 4'd5;
        tick();
        set_idle();
        tick();

        for (int i = 0; i < DEPTH; i++) write_a(AW'(i), DW'($urandom), 1'b0);
        clear_i = 1'b1;
        tick();
        repeat (DEPTH + 2) random_cycle(1'b1);
        set_idle();
        read_all();

        clear_i = 1'b1;
        tick();
        set_idle();
        repeat (7) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        repeat (DEPTH + 1) tick();

        repeat (400) random_cycle(1'b1);
        set_idle();
        repeat (DEPTH + 1) tick();

`ifdef RAM_DP_PARITY_EN
        write_a(4'd2, 16'h0001, 1'b1);
        write_a(4'd4, 16'h0003, 1'b0);
        a_rd_i   = 1'b1;
        a_addr_i = 4'd2;
        b_rd_i   = 1'b1;
        b_addr_i = 4'd4;
        tick();
        a_addr_i = 4'd4;
        b_addr_i = 4'd2;
        tick();
        set_idle();
        tick();
`endif

        read_all();
        repeat (3) tick();
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
